// File: rtl/tri_fetch_seq_if.sv
// rtl/tri_fetch_seq_if.sv - sequencer bundle: pass handshake, RAM read port, rasteriser control, status
interface tri_fetch_seq_if #(
    parameter int ADDR_W = 8
);
    logic                     start;
    logic                     load_done;
    logic [ADDR_W-1:0]        ram_read_addr;
    logic [31:0]              ram_read_data1;
    logic [31:0]              ram_read_data2;
    logic [31:0]              ram_read_data4;
    logic [31:0]              ram_read_data5;
    logic [31:0]              ram_read_data7;
    logic [31:0]              ram_read_data8;
    logic signed [31:0]       tri_x1;
    logic signed [31:0]       tri_y1;
    logic signed [31:0]       tri_x2;
    logic signed [31:0]       tri_y2;
    logic signed [31:0]       tri_x3;
    logic signed [31:0]       tri_y3;
    logic                     tri_reset;
    logic                     tri_finish;
    logic                     vid_buff_we;
    logic                     busy;
    logic                     done;
    logic [7:0]               tri_count;
    logic [7:0]               skip_count;
    logic                     timeout_err;

    modport master (
        input  start, load_done, tri_finish,
        input  ram_read_data1, ram_read_data2, ram_read_data4,
        input  ram_read_data5, ram_read_data7, ram_read_data8,
        output ram_read_addr,
        output tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3,
        output tri_reset, vid_buff_we, busy, done,
        output tri_count, skip_count, timeout_err
    );

    modport slave (
        output start, load_done, tri_finish,
        output ram_read_data1, ram_read_data2, ram_read_data4,
        output ram_read_data5, ram_read_data7, ram_read_data8,
        input  ram_read_addr,
        input  tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3,
        input  tri_reset, vid_buff_we, busy, done,
        input  tri_count, skip_count, timeout_err
    );
endinterface

// File: rtl/tri_fetch_seq.sv
// rtl/tri_fetch_seq.sv - fetches triangle records from RAM, bounds-checks them and runs the rasteriser per triangle
module tri_fetch_seq #(
    parameter int ADDR_W    = 8,
    parameter int NUM_TRI   = 4,
    parameter int BASE_ADDR = 9,
    parameter int STRIDE    = 9,
    parameter int RD_LAT    = 1,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int GUARD     = 2,
    parameter int TIMEOUT   = 400000
) (
    input  logic            clk,
    input  logic            reset,
    tri_fetch_seq_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_LOAD, S_ADDR, S_READ, S_CHECK,
        S_LAUNCH, S_RASTER, S_NEXT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);
    localparam logic [31:0]       RD_LAST   = 32'(RD_LAT - 1);
    localparam logic [31:0]       GUARD_C   = 32'(GUARD);
    localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [31:0]       NUM_TRI_C = 32'(NUM_TRI);

    state_t             r_state;
    logic [31:0]        r_idx;
    logic [31:0]        r_rd_cnt;
    logic [31:0]        r_ras_cnt;
    logic [ADDR_W-1:0]  r_rec_addr;
    logic [ADDR_W-1:0]  r_addr;
    logic signed [31:0] r_x1, r_y1, r_x2, r_y2, r_x3, r_y3;
    logic               r_tri_reset;
    logic               r_vid_we;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_tri_count;
    logic [7:0]         r_skip_count;
    logic               r_timeout_err;
    logic               w_in_bounds;

    function automatic logic in_range(input logic signed [31:0] v, input int lim);
        return (v >= 0) && (v < lim);
    endfunction

    always_comb begin
        w_in_bounds = in_range(r_x1, H_RES) && in_range(r_x2, H_RES) && in_range(r_x3, H_RES) &&
                      in_range(r_y1, V_RES) && in_range(r_y2, V_RES) && in_range(r_y3, V_RES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_rd_cnt      <= '0;
            r_ras_cnt     <= '0;
            r_rec_addr    <= '0;
            r_addr        <= '0;
            r_x1          <= '0;
            r_y1          <= '0;
            r_x2          <= '0;
            r_y2          <= '0;
            r_x3          <= '0;
            r_y3          <= '0;
            r_tri_reset   <= 1'b1;
            r_vid_we      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tri_count   <= '0;
            r_skip_count  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state       <= S_WAIT_LOAD;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_idx         <= '0;
                        r_rec_addr    <= BASE_A;
                        r_tri_count   <= '0;
                        r_skip_count  <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_WAIT_LOAD: begin
                    if (bus.load_done) begin
                        if (NUM_TRI_C == 32'd0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    r_addr   <= r_rec_addr;
                    r_rd_cnt <= '0;
                    r_state  <= S_READ;
                end
                S_READ: begin
                    if (r_rd_cnt == RD_LAST) begin
                        r_x1    <= $signed(bus.ram_read_data1);
                        r_y1    <= $signed(bus.ram_read_data2);
                        r_x2    <= $signed(bus.ram_read_data4);
                        r_y2    <= $signed(bus.ram_read_data5);
                        r_x3    <= $signed(bus.ram_read_data7);
                        r_y3    <= $signed(bus.ram_read_data8);
                        r_state <= S_CHECK;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 32'd1;
                    end
                end
                S_CHECK: begin
                    if (w_in_bounds) begin
                        r_state <= S_LAUNCH;
                    end else begin
                        if (r_skip_count != 8'hFF) r_skip_count <= r_skip_count + 8'd1;
                        r_state <= S_NEXT;
                    end
                end
                S_LAUNCH: begin
                    r_tri_reset <= 1'b0;
                    r_vid_we    <= 1'b1;
                    r_ras_cnt   <= '0;
                    r_state     <= S_RASTER;
                end
                S_RASTER: begin
                    // finish is only trusted after the guard window; it may still be high from the last triangle
                    if (bus.tri_finish && (r_ras_cnt >= GUARD_C)) begin
                        if (r_tri_count != 8'hFF) r_tri_count <= r_tri_count + 8'd1;
                        r_tri_reset <= 1'b1;
                        r_vid_we    <= 1'b0;
                        r_state     <= S_NEXT;
                    end else if (r_ras_cnt == TMO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_tri_reset   <= 1'b1;
                        r_vid_we      <= 1'b0;
                        r_state       <= S_NEXT;
                    end else begin
                        r_ras_cnt <= r_ras_cnt + 32'd1;
                    end
                end
                S_NEXT: begin
                    r_idx      <= r_idx + 32'd1;
                    r_rec_addr <= r_rec_addr + STRIDE_A;
                    if (r_idx + 32'd1 == NUM_TRI_C) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_ADDR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_read_addr = r_addr;
    assign bus.tri_x1        = r_x1;
    assign bus.tri_y1        = r_y1;
    assign bus.tri_x2        = r_x2;
    assign bus.tri_y2        = r_y2;
    assign bus.tri_x3        = r_x3;
    assign bus.tri_y3        = r_y3;
    assign bus.tri_reset     = r_tri_reset;
    assign bus.vid_buff_we   = r_vid_we;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.tri_count     = r_tri_count;
    assign bus.skip_count    = r_skip_count;
    assign bus.timeout_err   = r_timeout_err;
endmodule

// File: tb/tb_tri_fetch_seq.sv
// tb/tb_tri_fetch_seq.sv - randomized passes of tri_fetch_seq against a record-level reference model
module tb_tri_fetch_seq;
    localparam int NT    = 4;
    localparam int BASE  = 9;
    localparam int STR   = 9;
    localparam int GUARD = 2;
    localparam int TMO   = 50;
    localparam int H     = 640;
    localparam int V     = 480;
    localparam int NEVER = 1000000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tri_fetch_seq_if #(.ADDR_W(8)) bus ();
    tri_fetch_seq_if #(.ADDR_W(8)) bus0 ();

    tri_fetch_seq #(
        .ADDR_W(8), .NUM_TRI(NT), .BASE_ADDR(BASE), .STRIDE(STR), .RD_LAT(1),
        .H_RES(H), .V_RES(V), .GUARD(GUARD), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    tri_fetch_seq #(
        .ADDR_W(8), .NUM_TRI(0), .BASE_ADDR(BASE), .STRIDE(STR), .RD_LAT(1),
        .H_RES(H), .V_RES(V), .GUARD(GUARD), .TIMEOUT(TMO)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master)
    );

    logic [31:0] mem [256][6];

    assign bus.ram_read_data1 = mem[bus.ram_read_addr][0];
    assign bus.ram_read_data2 = mem[bus.ram_read_addr][1];
    assign bus.ram_read_data4 = mem[bus.ram_read_addr][2];
    assign bus.ram_read_data5 = mem[bus.ram_read_addr][3];
    assign bus.ram_read_data7 = mem[bus.ram_read_addr][4];
    assign bus.ram_read_data8 = mem[bus.ram_read_addr][5];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // rasteriser emulation and observation, evaluated mid-cycle
    int          dly [16];
    int          rast_idx = 0;
    int          rc = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  last_addr = 8'd0;
    logic [7:0]  obs_addr [$];
    int          obs_len [$];
    logic [31:0] obs_crd [$];

    initial begin
        int cur;
        for (int k = 0; k < 16; k++) dly[k] = 1;
        bus.tri_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.vid_buff_we && !prev_we) begin
                rc = 0;
                obs_crd.push_back(bus.tri_x1);
                obs_crd.push_back(bus.tri_y1);
                obs_crd.push_back(bus.tri_x2);
                obs_crd.push_back(bus.tri_y2);
                obs_crd.push_back(bus.tri_x3);
                obs_crd.push_back(bus.tri_y3);
            end else if (bus.vid_buff_we) begin
                rc++;
            end
            if (!bus.vid_buff_we && prev_we) begin
                obs_len.push_back(rc + 1);
                rast_idx++;
            end
            prev_we = bus.vid_buff_we;
            cur = (rast_idx < 16) ? dly[rast_idx] : 1;
            bus.tri_finish = bus.vid_buff_we ? (rc >= cur) : (cur == 0);
            if (bus.busy && bus.ram_read_addr != last_addr) begin
                obs_addr.push_back(bus.ram_read_addr);
                last_addr = bus.ram_read_addr;
            end
            check_eq("tri_reset_vs_we", {31'd0, bus.tri_reset}, {31'd0, !bus.vid_buff_we});
        end
    end

    function automatic bit coord_ok(input logic [31:0] v, input int lim);
        int s = $signed(v);
        return (s >= 0) && (s < lim);
    endfunction

    function automatic logic [31:0] rand_coord(input int lim);
        int r = $urandom_range(0, 9);
        if (r == 8) return ($urandom_range(0, 1) != 0) ? 32'(lim) : 32'hFFFF_FFFF;
        if (r == 9) return ($urandom_range(0, 1) != 0) ? 32'(lim - 1) : 32'd0;
        return 32'($urandom_range(0, lim - 1));
    endfunction

    function automatic int rand_dly();
        int r = $urandom_range(0, 9);
        if (r < 2)  return 0;
        if (r < 7)  return $urandom_range(1, 45);
        if (r == 7) return TMO - 1;
        if (r == 8) return TMO;
        return NEVER;
    endfunction

    task automatic check_reset_vals();
        check_eq("rst_addr",  {24'd0, bus.ram_read_addr}, 32'd0);
        check_eq("rst_x1",    bus.tri_x1, 32'd0);
        check_eq("rst_y1",    bus.tri_y1, 32'd0);
        check_eq("rst_x2",    bus.tri_x2, 32'd0);
        check_eq("rst_y2",    bus.tri_y2, 32'd0);
        check_eq("rst_x3",    bus.tri_x3, 32'd0);
        check_eq("rst_y3",    bus.tri_y3, 32'd0);
        check_eq("rst_trirst", {31'd0, bus.tri_reset}, 32'd1);
        check_eq("rst_we",    {31'd0, bus.vid_buff_we}, 32'd0);
        check_eq("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done",  {31'd0, bus.done}, 32'd0);
        check_eq("rst_tcnt",  {24'd0, bus.tri_count}, 32'd0);
        check_eq("rst_scnt",  {24'd0, bus.skip_count}, 32'd0);
        check_eq("rst_tmo",   {31'd0, bus.timeout_err}, 32'd0);
    endtask

    task automatic run_pass(input bit directed);
        logic [31:0] rec [4][6];
        logic [7:0]  exp_addr [$];
        int          exp_len [$];
        logic [31:0] exp_crd [$];
        int          exp_tri = 0;
        int          exp_skip = 0;
        int          exp_to = 0;
        int          n_r = 0;
        int          d;
        int          cyc;
        bit          ok;
        logic [7:0]  a;
        int          ddir [4] = '{40, 1, 1, 0};

        for (int i = 0; i < NT; i++) begin
            for (int j = 0; j < 6; j++) rec[i][j] = rand_coord((j % 2 == 0) ? H : V);
        end
        if (directed) begin
            rec[0] = '{32'd10, 32'd10, 32'd100, 32'd20, 32'd50, 32'd80};
            rec[1] = '{32'd5, 32'd5, 32'd640, 32'd5, 32'd5, 32'd5};
            rec[2] = '{32'd5, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5, 32'd5};
            rec[3] = '{32'd639, 32'd479, 32'd0, 32'd0, 32'd1, 32'd1};
        end
        for (int k = 0; k < 16; k++) dly[k] = 1;

        for (int i = 0; i < NT; i++) begin
            a = 8'((BASE + i * STR) % 256);
            exp_addr.push_back(a);
            ok = 1'b1;
            for (int j = 0; j < 6; j++) begin
                mem[a][j] = rec[i][j];
                if (!coord_ok(rec[i][j], (j % 2 == 0) ? H : V)) ok = 1'b0;
            end
            if (!ok) begin
                exp_skip++;
            end else begin
                d = directed ? ddir[i] : rand_dly();
                dly[n_r] = d;
                if (d <= TMO - 1) begin
                    exp_len.push_back(((d > GUARD) ? d : GUARD) + 1);
                    exp_tri++;
                end else begin
                    exp_len.push_back(TMO);
                    exp_to = 1;
                end
                for (int j = 0; j < 6; j++) exp_crd.push_back(rec[i][j]);
                n_r++;
            end
        end

        obs_addr.delete();
        obs_len.delete();
        obs_crd.delete();
        rast_idx  = 0;
        last_addr = bus.ram_read_addr;

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("start_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("start_done", {31'd0, bus.done}, 32'd0);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        bus.load_done = 1'b1;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        if (bus.busy) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        cyc = 0;
        while (!bus.done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        bus.load_done = 1'b0;

        check_eq("pass_done",  {31'd0, bus.done}, 32'd1);
        check_eq("pass_busy",  {31'd0, bus.busy}, 32'd0);
        check_eq("pass_we",    {31'd0, bus.vid_buff_we}, 32'd0);
        check_eq("tri_count",  {24'd0, bus.tri_count}, 32'(exp_tri));
        check_eq("skip_count", {24'd0, bus.skip_count}, 32'(exp_skip));
        check_eq("timeout",    {31'd0, bus.timeout_err}, 32'(exp_to));
        check_eq("n_addr",     32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++)
            check_eq("rec_addr", {24'd0, obs_addr[k]}, {24'd0, exp_addr[k]});
        check_eq("n_raster",   32'(obs_len.size()), 32'(exp_len.size()));
        for (int k = 0; k < exp_len.size() && k < obs_len.size(); k++)
            check_eq("raster_len", 32'(obs_len[k]), 32'(exp_len[k]));
        for (int k = 0; k < exp_crd.size() && k < obs_crd.size(); k++)
            check_eq("coord", obs_crd[k], exp_crd[k]);
    endtask

    task automatic reset_mid_raster();
        int cyc;
        logic [7:0] a;
        for (int i = 0; i < NT; i++) begin
            a = 8'((BASE + i * STR) % 256);
            for (int j = 0; j < 6; j++) mem[a][j] = 32'(j + 1);
        end
        for (int k = 0; k < 16; k++) dly[k] = NEVER;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.load_done = 1'b1;
        cyc = 0;
        while (!bus.vid_buff_we && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reached_raster", {31'd0, bus.vid_buff_we}, 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        bus.load_done = 1'b0;
        check_reset_vals();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.load_done = 1'b0;
        bus0.start = 1'b0;
        bus0.load_done = 1'b0;
        bus0.tri_finish = 1'b0;
        bus0.ram_read_data1 = '0;
        bus0.ram_read_data2 = '0;
        bus0.ram_read_data4 = '0;
        bus0.ram_read_data5 = '0;
        bus0.ram_read_data7 = '0;
        bus0.ram_read_data8 = '0;
        for (int a = 0; a < 256; a++)
            for (int j = 0; j < 6; j++) mem[a][j] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_vals();

        run_pass(1'b1);
        reset_mid_raster();
        for (int p = 0; p < 10; p++) run_pass(1'b0);

        // zero-record instance: DONE one cycle after load_done, address never driven
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        check_eq("n0_busy", {31'd0, bus0.busy}, 32'd1);
        bus0.load_done = 1'b1;
        @(negedge clk);
        check_eq("n0_done", {31'd0, bus0.done}, 32'd1);
        check_eq("n0_idle", {31'd0, bus0.busy}, 32'd0);
        check_eq("n0_addr", {24'd0, bus0.ram_read_addr}, 32'd0);
        check_eq("n0_we",   {31'd0, bus0.vid_buff_we}, 32'd0);
        bus0.load_done = 1'b0;
        cyc = 0;
        repeat (3) @(negedge clk);
        check_eq("n0_done_hold", {31'd0, bus0.done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
